// File: rtl/vga_rx_pkg.sv
// Shared types and standard 640x480@60 timing constants for the VGA timing receiver.
package vga_rx_pkg;

  // Lock state of the receiver: hunting, collecting good frames, locked.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  // Standard horizontal timing in pixel ticks.
  localparam int H_ACTIVE_STD = 640;
  localparam int H_FRONT_STD  = 16;
  localparam int H_SYNC_STD   = 96;
  localparam int H_BACK_STD   = 48;
  localparam int H_TOTAL_STD  = 800;

  // Standard vertical timing in lines.
  localparam int V_ACTIVE_STD = 480;
  localparam int V_FRONT_STD  = 10;
  localparam int V_SYNC_STD   = 2;
  localparam int V_BACK_STD   = 33;
  localparam int V_TOTAL_STD  = 525;

  localparam int CW_STD = 10;

  // Internal visibility for checkers: lock state plus sampled sync history.
  typedef struct packed {
    lock_state_e state;
    logic        hs_s;
    logic        vs_s;
    logic        de_s;
    logic        de_rise;
    logic        frame_bad;
    logic        hs_seen;
    logic        vs_seen;
  } rx_dbg_t;

endpackage

// File: rtl/vga_timing_receiver_if.sv
// Bundle of the timing input stream and the recovered pixel/status outputs.
//
// Transfer semantics: there is no backpressure. h_sync/v_sync/DE are
// sampled on every clk edge where pix_en=1 and ignored otherwise. On the
// output side pix_valid is a 1-clk qualifier for x_pixel/y_pixel; the
// coordinates hold their last value whenever pix_valid=0.
interface vga_timing_receiver_if #(
  parameter int CW = 10
);
  import vga_rx_pkg::*;

  // timing stream from the source
  logic          pix_en;
  logic          h_sync;
  logic          v_sync;
  logic          DE;

  // recovered pixel stream and status
  logic [CW-1:0] x_pixel;
  logic [CW-1:0] y_pixel;
  logic          pix_valid;
  logic          line_start;
  logic          frame_start;
  logic          locked;
  logic [CW-1:0] h_total;
  logic [CW-1:0] v_total;
  logic          timing_err;
  rx_dbg_t       dbg;

  // timing source side
  modport master (
    output pix_en, h_sync, v_sync, DE,
    input  x_pixel, y_pixel, pix_valid, line_start, frame_start,
    input  locked, h_total, v_total, timing_err, dbg
  );

  // receiver side
  modport slave (
    input  pix_en, h_sync, v_sync, DE,
    output x_pixel, y_pixel, pix_valid, line_start, frame_start,
    output locked, h_total, v_total, timing_err, dbg
  );

endinterface

// File: rtl/vga_sync_sampler.sv
// Keeps the previous tick's sync/DE samples and derives edge strobes
// between that history and the value being sampled on the current tick.
module vga_sync_sampler
  import vga_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic h_sync,
  input  logic v_sync,
  input  logic DE,
  output logic hs_s,
  output logic vs_s,
  output logic de_s,
  output logic hs_fall,
  output logic vs_fall,
  output logic de_rise,
  output logic de_fall
);

  // Sample history; syncs idle high so a stream starting in sync is not a fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_s <= 1'b1;
      vs_s <= 1'b1;
      de_s <= 1'b0;
    end else if (pix_en) begin
      hs_s <= h_sync;
      vs_s <= v_sync;
      de_s <= DE;
    end
  end

  // Edge strobes are only meaningful on a tick, so qualify with pix_en.
  always_comb begin
    hs_fall = pix_en &  hs_s & ~h_sync;
    vs_fall = pix_en &  vs_s & ~v_sync;
    de_rise = pix_en & ~de_s &  DE;
    de_fall = pix_en &  de_s & ~DE;
  end

endmodule

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: recovers pixel coordinates from h_sync/v_sync/DE,
// measures line and frame lengths and tracks lock against the nominal timing.
module vga_timing_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_STD,
  parameter int H_TOTAL     = H_TOTAL_STD,
  parameter int V_ACTIVE    = V_ACTIVE_STD,
  parameter int V_TOTAL     = V_TOTAL_STD,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = CW_STD
) (
  input logic                  clk,
  input logic                  reset,
  vga_timing_receiver_if.slave bus
);

  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_TOT_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_TOT_C = CW'(V_TOTAL);
  localparam int            GW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_FRAMES);

  // All counters stick at their maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  logic pix_en;
  logic de_now;
  assign pix_en = bus.pix_en;
  assign de_now = bus.DE;

  logic hs_s, vs_s, de_s;
  logic hs_fall, vs_fall, de_rise, de_fall;

  vga_sync_sampler u_sampler (
    .clk     (clk),
    .reset   (reset),
    .pix_en  (pix_en),
    .h_sync  (bus.h_sync),
    .v_sync  (bus.v_sync),
    .DE      (bus.DE),
    .hs_s    (hs_s),
    .vs_s    (vs_s),
    .de_s    (de_s),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall),
    .de_rise (de_rise),
    .de_fall (de_fall)
  );

  // running coordinates and measurement state
  logic [CW-1:0] x_run, y_run;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          hs_seen, vs_seen, frame_bad;

  // registered outputs
  logic [CW-1:0] x_pixel_q, y_pixel_q, h_total_q, v_total_q;
  logic          pix_valid_q, line_start_q, frame_start_q, timing_err_q;

  // lock FSM
  lock_state_e   state, state_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic          locked;

  // per-tick decisions
  logic [CW-1:0] y_after_de;
  logic [CW-1:0] h_meas;
  logic          de_err, h_err, frame_eval, frame_good;

  // Decisions for the current tick, all derived from state before the edge.
  always_comb begin
    y_after_de = de_fall ? sat_inc(y_run) : y_run;
    h_meas     = sat_inc(h_cnt);
    // x_run already counts every DE tick of the line that just ended
    de_err     = de_fall && (x_run != H_ACT_C);
    h_err      = hs_fall && hs_seen && (h_meas != H_TOT_C);
    frame_eval = vs_fall && vs_seen;
    // a line ending on the vs_fall tick counts toward the frame being closed
    frame_good = !frame_bad && !de_err && (v_cnt == V_TOT_C) && (y_after_de == V_ACT_C);
  end

  // Column/row tracking: DE advances the column, de_fall starts a new row, vs_fall restarts rows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_run <= '0;
      y_run <= '0;
    end else if (pix_en) begin
      if (de_now) begin
        x_run <= sat_inc(x_run);
      end else if (de_fall) begin
        x_run <= '0;
      end
      if (vs_fall) begin
        y_run <= '0;
      end else if (de_fall) begin
        y_run <= sat_inc(y_run);
      end
    end
  end

  // Line/frame length counters and frame health; a vs_fall closes the frame before
  // any coincident hs_fall is counted into the new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      hs_seen   <= 1'b0;
      vs_seen   <= 1'b0;
      frame_bad <= 1'b0;
    end else if (pix_en) begin
      h_cnt   <= hs_fall ? '0 : sat_inc(h_cnt);
      hs_seen <= hs_seen | hs_fall;
      vs_seen <= vs_seen | vs_fall;
      if (vs_fall) begin
        v_cnt     <= hs_fall ? CW'(1) : '0;
        frame_bad <= h_err;
      end else begin
        if (hs_fall) begin
          v_cnt <= sat_inc(v_cnt);
        end
        if (h_err || de_err) begin
          frame_bad <= 1'b1;
        end
      end
    end
  end

  // Output registers: pulses clear every clk, coordinates and measurements hold between ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_pixel_q     <= '0;
      y_pixel_q     <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      pix_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      pix_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      if (pix_en) begin
        if (de_now) begin
          pix_valid_q   <= 1'b1;
          x_pixel_q     <= x_run;
          y_pixel_q     <= y_run;
          line_start_q  <= (x_run == '0);
          frame_start_q <= (x_run == '0) && (y_run == '0);
        end
        if (hs_fall && hs_seen) begin
          h_total_q <= h_meas;
        end
        if (frame_eval) begin
          v_total_q <= v_cnt;
        end
        if (h_err || de_err || (frame_eval && !frame_good)) begin
          timing_err_q <= 1'b1;
        end
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else if (pix_en) begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Lock FSM next state: only a closed, measured frame can move it.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    if (frame_eval) begin
      case (state)
        SEARCH: begin
          if (frame_good) begin
            good_nxt  = GW'(1);
            state_nxt = (LOCK_FRAMES == 1) ? LOCKED : ACQUIRE;
          end else begin
            good_nxt  = '0;
          end
        end
        ACQUIRE: begin
          if (frame_good) begin
            good_nxt = good_cnt + GW'(1);
            if (good_nxt == LOCK_C) begin
              state_nxt = LOCKED;
            end
          end else begin
            good_nxt  = '0;
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            good_nxt  = '0;
            state_nxt = SEARCH;
          end
        end
        default: begin
          good_nxt  = '0;
          state_nxt = SEARCH;
        end
      endcase
    end
  end

  // Lock FSM outputs: locked straight from the state register, plus debug view.
  always_comb begin
    locked            = (state == LOCKED);
    bus.dbg           = '0;
    bus.dbg.state     = state;
    bus.dbg.hs_s      = hs_s;
    bus.dbg.vs_s      = vs_s;
    bus.dbg.de_s      = de_s;
    bus.dbg.de_rise   = de_rise;
    bus.dbg.frame_bad = frame_bad;
    bus.dbg.hs_seen   = hs_seen;
    bus.dbg.vs_seen   = vs_seen;
  end

  assign bus.x_pixel     = x_pixel_q;
  assign bus.y_pixel     = y_pixel_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked      = locked;
  assign bus.h_total     = h_total_q;
  assign bus.v_total     = v_total_q;
  assign bus.timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver using a scaled-down raster (24x10 ticks/lines)
// with randomized pix_en spacing and randomized fault placement.
`timescale 1ns/1ps
module tb_vga_timing_receiver;
  import vga_rx_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int LF = 2;
  localparam int CW = 10;
  localparam int SAT = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_timing_receiver_if #(.CW(CW)) bus ();

  vga_timing_receiver #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(LF), .CW(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Line length = tick distance between sync falls; frame length = number of
  // sync falls between vsync falls; locked = run of good frames >= LF.
  int  m_tick, m_last_hs, m_x, m_y, m_lines, m_run;
  bit  m_vs_seen, m_bad, m_ph, m_pv, m_pd;
  logic [CW-1:0] e_x, e_y, e_ht, e_vt;
  logic          e_pv, e_ls, e_fs, e_lock, e_err;

  function automatic int smin(input int a);
    return (a > SAT) ? SAT : a;
  endfunction

  task automatic m_clear();
    m_tick = 0; m_last_hs = -1; m_x = 0; m_y = 0; m_lines = 0; m_run = 0;
    m_vs_seen = 0; m_bad = 0; m_ph = 1; m_pv = 1; m_pd = 0;
    e_x = '0; e_y = '0; e_ht = '0; e_vt = '0;
    e_pv = 0; e_ls = 0; e_fs = 0; e_lock = 0; e_err = 0;
  endtask

  task automatic m_step(input bit h, input bit v, input bit d);
    bit hf, vf, df, de_err, good;
    int meas;
    hf = m_ph && !h;
    vf = m_pv && !v;
    df = m_pd && !d;
    de_err = 0;
    if (d) begin
      e_pv = 1; e_x = CW'(m_x); e_y = CW'(m_y);
      e_ls = (m_x == 0); e_fs = (m_x == 0) && (m_y == 0);
      m_x = smin(m_x + 1);
    end
    if (df) begin
      de_err = (m_x != HA);
      m_x = 0;
      m_y = smin(m_y + 1);
    end
    if (vf) begin
      if (m_vs_seen) begin
        e_vt = CW'(m_lines);
        good = !m_bad && !de_err && (m_lines == VT) && (m_y == VA);
        m_run = good ? m_run + 1 : 0;
        if (!good) e_err = 1;
        e_lock = (m_run >= LF);
      end
      m_vs_seen = 1; m_lines = 0; m_bad = 0; m_y = 0;
    end else if (de_err) begin
      m_bad = 1;
    end
    if (de_err) e_err = 1;
    if (hf) begin
      if (m_last_hs >= 0) begin
        meas = smin(m_tick - m_last_hs);
        e_ht = CW'(meas);
        if (meas != HT) begin
          e_err = 1; m_bad = 1;
        end
      end
      m_last_hs = m_tick;
      m_lines = smin(m_lines + 1);
    end
    m_ph = h; m_pv = v; m_pd = d;
    m_tick++;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_clear();
    end else begin
      e_pv = 0; e_ls = 0; e_fs = 0; e_err = 0;
      if (bus.pix_en) m_step(bus.h_sync, bus.v_sync, bus.DE);
    end
  end

  // ---------------- scoreboard: every clk ----------------
  always @(negedge clk) begin
    n_tests++;
    if (bus.x_pixel !== e_x || bus.y_pixel !== e_y || bus.pix_valid !== e_pv ||
        bus.line_start !== e_ls || bus.frame_start !== e_fs || bus.locked !== e_lock ||
        bus.h_total !== e_ht || bus.v_total !== e_vt || bus.timing_err !== e_err) begin
      n_fail++;
      $display("FAIL cycle t=%0t got x=%0d y=%0d pv=%0b ls=%0b fs=%0b lk=%0b ht=%0d vt=%0d err=%0b expected x=%0d y=%0d pv=%0b ls=%0b fs=%0b lk=%0b ht=%0d vt=%0d err=%0b",
               $time, bus.x_pixel, bus.y_pixel, bus.pix_valid, bus.line_start, bus.frame_start,
               bus.locked, bus.h_total, bus.v_total, bus.timing_err,
               e_x, e_y, e_pv, e_ls, e_fs, e_lock, e_ht, e_vt, e_err);
    end
  end

  // event tallies used by the hand-computed checks
  int pv_cnt = 0, fs_cnt = 0, err_cnt = 0;
  logic [CW-1:0] first_err_ht = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.pix_valid) pv_cnt++;
      if (bus.frame_start) fs_cnt++;
      if (bus.timing_err) begin
        if (err_cnt == 0) first_err_ht = bus.h_total;
        err_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int stretch_line = -1, short_line = -1, stall_line = -1, reset_line = -1;
  bit coinc = 0;

  task automatic tick(input bit h, input bit v, input bit d);
    bus.h_sync = h; bus.v_sync = v; bus.DE = d; bus.pix_en = 1'b1;
    @(negedge clk);
    bus.pix_en = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_x_pixel", 32'(bus.x_pixel), 0);
    check("rst_y_pixel", 32'(bus.y_pixel), 0);
    check("rst_pulses", {bus.pix_valid, bus.line_start, bus.frame_start, bus.timing_err}, 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_totals", {bus.h_total, bus.v_total}, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_frame();
    int len, vst;
    bit hs, vs, de;
    vst = coinc ? HA + HF : 0;
    for (int v = 0; v < VT; v++) begin
      if (v == reset_line) do_reset();
      len = (v == stretch_line) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        hs = !(h >= HA + HF && h < HA + HF + HS);
        de = (v < VA) && (h < ((v == short_line) ? HA - 1 : HA));
        vs = !((v == VA + VF && h >= vst) || (v > VA + VF && v < VA + VF + VS) ||
               (v == VA + VF + VS && h < vst));
        tick(hs, vs, de);
        if (v == stall_line && h == 5) repeat (1000) @(negedge clk);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m_clear();
    bus.pix_en = 1'b0; bus.h_sync = 1'b1; bus.v_sync = 1'b1; bus.DE = 1'b0;
    repeat (4) @(negedge clk);
    check("init_outputs", {bus.x_pixel, bus.y_pixel, bus.h_total, bus.v_total}, 0);
    check("init_flags", {bus.pix_valid, bus.line_start, bus.frame_start, bus.locked, bus.timing_err}, 0);
    reset = 1'b1;
    @(negedge clk);

    // nominal: arm on frame 0, good frames evaluated at frames 1 and 2
    err_cnt = 0;
    run_frame();
    run_frame();
    check("nom_locked_f1", 32'(bus.locked), 0);
    run_frame();
    check("nom_locked_f2", 32'(bus.locked), 1);
    check("nom_h_total", 32'(bus.h_total), HT);
    check("nom_v_total", 32'(bus.v_total), VT);
    pv_cnt = 0; fs_cnt = 0;
    run_frame();
    check("nom_pixels", pv_cnt, HA * VA);
    check("nom_frame_starts", fs_cnt, 1);
    check("nom_last_x", 32'(bus.x_pixel), HA - 1);
    check("nom_last_y", 32'(bus.y_pixel), VA - 1);
    check("nom_errors", err_cnt, 0);

    // long line: one error at the sync fall, one at the frame close
    err_cnt = 0;
    stretch_line = $urandom_range(0, VA - 1);
    run_frame();
    stretch_line = -1;
    check("long_errors", err_cnt, 2);
    check("long_h_total", 32'(first_err_ht), HT + 1);
    check("long_unlocked", 32'(bus.locked), 0);
    run_frame();
    check("long_relock_f1", 32'(bus.locked), 0);
    run_frame();
    check("long_relock_f2", 32'(bus.locked), 1);

    // vsync fall coincident with hsync fall
    err_cnt = 0;
    coinc = 1;
    run_frame();
    run_frame();
    coinc = 0;
    check("coinc_errors", err_cnt, 0);
    check("coinc_v_total", 32'(bus.v_total), VT);
    check("coinc_locked", 32'(bus.locked), 1);

    // one active line one pixel short
    err_cnt = 0; pv_cnt = 0;
    short_line = $urandom_range(0, VA - 1);
    run_frame();
    check("short_errors", err_cnt, 2);
    check("short_pixels", pv_cnt, HA * VA - 1);
    check("short_unlocked", 32'(bus.locked), 0);
    check("short_last_x", 32'(bus.x_pixel), (short_line == VA - 1) ? HA - 2 : HA - 1);
    short_line = -1;

    // long pix_en stall mid-line
    err_cnt = 0;
    stall_line = 2;
    run_frame();
    stall_line = -1;
    run_frame();
    check("stall_errors", err_cnt, 0);
    check("stall_locked", 32'(bus.locked), 1);

    // reset mid-frame, then re-arm and relock
    reset_line = 3;
    run_frame();
    reset_line = -1;
    run_frame();
    check("rst_relock_f1", 32'(bus.locked), 0);
    run_frame();
    check("rst_relock_f2", 32'(bus.locked), 1);
    check("rst_h_total", 32'(bus.h_total), HT);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
